fsm_multiplier: RTL and testbench
=================================

// Module: fsm_multiplier
// PURPOSE
//   Sequential shift-and-add unsigned multiplier controlled by a small FSM.
//   A one-cycle in_en strobe captures operands a and b. The block then iterates one multiplier bit per clock.
//   When done, it presents the 2*WIDTH-bit product with a one-cycle out_en strobe.
//   Area-lean datapath block: one adder is reused instead of a combinational array multiplier.
// PARAMETERS
//   WIDTH  8  operand width in bits; product width is 2*WIDTH
// PORTS
//   clk     in   1        rising-edge clock, single clock domain
//   rst     in   1        asynchronous, active-low reset (asserted when 0)
//   in_en   in   1        start strobe; operands are sampled on the clock edge where in_en=1 in IDLE
//   a       in   WIDTH    multiplicand, unsigned
//   b       in   WIDTH    multiplier, unsigned
//   prdct   out  2*WIDTH  registered product; holds the last result
//   out_en  out  1        one-cycle pulse, high while a new prdct is first presented
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, prdct=0, out_en=0, internal registers=0.
//     Reset mid-operation aborts the job; no out_en is produced for it.
//   - States: IDLE, CALC.
//     IDLE->CALC when in_en=1. CALC->IDLE after WIDTH iterations.
//   - Capture edge E0 (IDLE, in_en=1):
//     mcand <= {WIDTH'b0,a} (2*WIDTH wide), mplier <= b, acc <= 0, cnt <= 0.
//   - Iteration edges E1..EW (CALC), each edge:
//     acc <= acc + (mplier[0] ? mcand : 0); mcand <<= 1; mplier >>= 1; cnt++.
//   - At edge EW the final sum is written to prdct and out_en<=1 on that same edge; state->IDLE.
//   - out_en clears at E(W+1) unless that edge completes another job.
//   - Latency: out_en is high in the cycle starting WIDTH edges after the capture edge (8 cycles at default).
//   - Throughput: a new in_en is accepted at E(W+1), while out_en is high.
//   - in_en during CALC is ignored. Operand inputs may change freely after E0.
//   - Arithmetic is unsigned and exact; 2*WIDTH bits never overflow (255*255=0xFE01).
//   - Zero operands still take the full latency when the optional feature is off.
//   - prdct changes only at completion edges and at reset.
// CONFIGURATION
//   FSM_MULT_EARLY_TERM_EN defined:
//     - CALC also completes at the first iteration edge where the shifted mplier becomes 0.
//     - The result is written on that edge, so latency = max(1, index of highest set bit of b + 1) edges after E0.
//     - b=0 completes at E1 with prdct=0.
//   Undefined: fixed WIDTH-edge latency for every operand pair.
// STRUCTURE
//   - Shared package fsm_mult_pkg holds:
//     - state typedef enum {IDLE, CALC};
//     - default WIDTH constant;
//     - CNT_W = $clog2(WIDTH+1).
//   - One natural sub-module, fsm_mult_datapath: acc/mcand/mplier registers and the adder, driven by load/step controls.
//   - The top level keeps the FSM, the counter and the output registers.
// TESTING
//   - Reset: hold rst=0 for 70 ns, release, 20 ns clock -> prdct=0x0000 and out_en=0 until the first completion.
//   - Basic: in_en=1 for one cycle with a=5, b=5 -> out_en high exactly one cycle, 8 cycles after capture, with prdct=0x0019.
//   - Extremes: a=255, b=255 -> 0xFE01; a=0, b=200 -> 0x0000; a=1, b=128 -> 0x0080, each with full latency.
//   - Ignore-while-busy: pulse in_en with a=3, b=7, then pulse in_en with a=9, b=9 two cycles later -> exactly one out_en, prdct=0x0015.
//   - Back-to-back: second in_en asserted in the out_en cycle -> second result 8 cycles later; prdct holds the first value in between.
//   - Abort: assert rst at cycle 4 of a job -> prdct=0 and out_en=0 immediately, no out_en afterwards.
//   - Early-term build: a=5, b=5 -> out_en 3 cycles after capture; b=0 -> out_en 1 cycle after capture.

Source files
------------

// File: rtl/fsm_mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier slice.
//   state_t   : controller states (IDLE, CALC)
//   DEF_WIDTH : default operand width
//   CNT_W     : iteration counter width for DEF_WIDTH
//   cnt_width : counter width for an arbitrary operand width
`timescale 1ns/1ps
package fsm_mult_pkg;
  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned CNT_W     = $clog2(DEF_WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/fsm_multiplier_if.sv
// Operand/result bundle of the multiplier.
//   in_en  : start strobe          a, b   : unsigned operands
//   prdct  : 2*WIDTH-bit product   out_en : one-cycle result strobe
// master = requester (drives operands), slave = multiplier.
`timescale 1ns/1ps
interface fsm_multiplier_if
  import fsm_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic               in_en;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] prdct;
  logic               out_en;

  modport master (output in_en, a, b, input prdct, out_en);
  modport slave  (input in_en, a, b, output prdct, out_en);
endinterface

// File: rtl/fsm_mult_datapath.sv
// Shift-and-add datapath: accumulator, shifting multiplicand and multiplier
// around a single adder.
//   clk, rst_n       : clock, async active-low reset
//   load             : capture a/b, clear accumulator
//   step             : perform one iteration
//   sum              : acc plus the current partial product (next acc value)
//   mplier_rest_zero : multiplier bits above bit 0 are all zero, i.e. the
//                      multiplier becomes zero after the current step
`timescale 1ns/1ps
module fsm_mult_datapath
  import fsm_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] sum,
  output logic               mplier_rest_zero
);
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;

  assign sum              = acc + (mplier[0] ? mcand : '0);
  assign mplier_rest_zero = ((mplier >> 1) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
    end else if (step) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
endmodule

// File: rtl/fsm_multiplier.sv
// Sequential unsigned multiplier: one multiplier bit per clock, single adder.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset (aborts any job in flight)
//   bus   : fsm_multiplier_if.slave (in_en, a, b in; prdct, out_en out)
// Optional feature macro FSM_MULT_EARLY_TERM_EN: finish as soon as the
// remaining multiplier bits are zero instead of after WIDTH iterations.
`timescale 1ns/1ps
module fsm_multiplier
  import fsm_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  fsm_multiplier_if.slave    bus
);
  localparam int unsigned CW = cnt_width(WIDTH);

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      cnt;
  logic               load;
  logic               step;
  logic               done;
  logic               last_iter;
  logic [2*WIDTH-1:0] sum;
  logic               mplier_rest_zero;

  fsm_mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk              (clk),
    .rst_n            (rst),
    .load             (load),
    .step             (step),
    .a                (bus.a),
    .b                (bus.b),
    .sum              (sum),
    .mplier_rest_zero (mplier_rest_zero)
  );

  // cnt holds the number of completed iterations, so the WIDTH-th
  // iteration is the one taken while cnt == WIDTH-1.
`ifdef FSM_MULT_EARLY_TERM_EN
  assign last_iter = (cnt == CW'(WIDTH - 1)) || mplier_rest_zero;
`else
  assign last_iter = (cnt == CW'(WIDTH - 1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.in_en) state_next = CALC;
      CALC: if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    step = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: load = bus.in_en;
      CALC: begin
        step = 1'b1;
        done = last_iter;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The final sum is taken straight from the adder so the result lands
  // on the same edge as the last iteration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.prdct  <= '0;
      bus.out_en <= 1'b0;
    end else begin
      bus.out_en <= done;
      if (done) bus.prdct <= sum;
    end
  end
endmodule

// File: tb/tb_fsm_multiplier.sv
`timescale 1ns/1ps
module tb_fsm_multiplier;
  localparam int unsigned W = 8;

  typedef struct {
    logic [2*W-1:0] prod;
    int unsigned    due;
  } exp_t;

  logic        clk;
  logic        rst;
  int unsigned cyc;
  int unsigned busy_until;
  int unsigned n_checks;
  int unsigned n_fails;
  logic [2*W-1:0] last_prdct;
  exp_t        sb[$];

  fsm_multiplier_if #(.WIDTH(W)) bus ();

  fsm_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int unsigned job_lat(input logic [W-1:0] bv);
    int unsigned l;
    l = W;
`ifdef FSM_MULT_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < int'(W); i++) if (bv[i]) l = i + 1;
`else
    if (bv == '0) l = W;
`endif
    return l;
  endfunction

  // Monitor: every cycle out_en must match the scoreboard head's due cycle;
  // otherwise prdct must hold the last completed result.
  always @(negedge clk) begin
    logic exp_out;
    exp_out = (sb.size() > 0) && (sb[0].due == cyc);
    check_eq("out_en", {31'b0, bus.out_en}, {31'b0, exp_out});
    if (exp_out) begin
      check_eq("prdct", {16'b0, bus.prdct}, {16'b0, sb[0].prod});
      last_prdct = sb[0].prod;
      void'(sb.pop_front());
    end else begin
      check_eq("prdct_hold", {16'b0, bus.prdct}, {16'b0, last_prdct});
    end
  end

  task automatic pulse(input logic [W-1:0] ta, input logic [W-1:0] tbv);
    exp_t e;
    @(negedge clk);
    bus.in_en = 1'b1;
    bus.a     = ta;
    bus.b     = tbv;
    if (cyc + 1 > busy_until) begin
      e.prod     = (2*W)'(ta) * (2*W)'(tbv);
      e.due      = cyc + 1 + job_lat(tbv);
      busy_until = e.due;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.in_en = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
  endtask

  task automatic wait_drain();
    int unsigned k;
    k = 0;
    while (sb.size() > 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check_eq("drain", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    cyc        = 0;
    busy_until = 0;
    n_checks   = 0;
    n_fails    = 0;
    last_prdct = '0;
    rst        = 1'b0;
    bus.in_en  = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    #70 rst = 1'b1;
    repeat (2) @(negedge clk);

    // basic and extremes
    pulse(8'd5, 8'd5);     wait_drain();
    pulse(8'd255, 8'd255); wait_drain();
    pulse(8'd0, 8'd200);   wait_drain();
    pulse(8'd1, 8'd128);   wait_drain();
    pulse(8'd7, 8'd0);     wait_drain();

    // second strobe two cycles into a job is ignored
    pulse(8'd3, 8'd7);
    pulse(8'd9, 8'd9);
    wait_drain();

    // back-to-back: next strobe lands in the out_en cycle
    pulse(8'd12, 8'd11);
    repeat (job_lat(8'd11) - 1) @(negedge clk);
    pulse(8'd200, 8'd3);
    wait_drain();

    // random jobs with random gaps
    for (int j = 0; j < 8; j++) begin
      pulse(W'($urandom), W'($urandom));
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
    wait_drain();

    // abort: reset on the 4th iteration edge of a job
    pulse(8'd200, 8'd100);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #5;
    rst = 1'b0;
    sb.delete();
    last_prdct = '0;
    busy_until = 0;
    #1;
    check_eq("abort_prdct", {16'b0, bus.prdct}, 32'd0);
    check_eq("abort_out_en", {31'b0, bus.out_en}, 32'd0);
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    repeat (12) @(negedge clk);

    // recovery after abort
    pulse(8'd13, 8'd17);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
